// File: rtl/fib_seq_ctrl_pkg.sv
// Shared definitions for the Fibonacci sequencing controller: state encoding,
// mux select codes and the step-exit helper.
package fib_pkg;

    localparam int DATA_WIDTH     = 4;
    localparam int STATE_WIDTH    = 3;
    localparam int STEP_CNT_WIDTH = 8;

    localparam logic MUX_SEL_ADD = 1'b0;
    localparam logic MUX_SEL_DEC = 1'b1;

    typedef enum logic [STATE_WIDTH-1:0] {
        ST_IDLE     = 3'd0,
        ST_STEP     = 3'd1,
        ST_LOAD     = 3'd2,
        ST_CHK      = 3'd3,
        ST_ON_WAIT  = 3'd4,
        ST_OFF_WAIT = 3'd5,
        ST_GAP_WAIT = 3'd6,
        ST_DONE     = 3'd7
    } state_t;

    // Iteration stops when the count is exhausted or the hang guard trips.
    function automatic logic step_exit(input logic                      zero,
                                       input logic [STEP_CNT_WIDTH-1:0] cnt,
                                       input logic [STEP_CNT_WIDTH-1:0] limit);
        return zero | (cnt == limit);
    endfunction

endpackage

// File: rtl/fib_seq_ctrl_if.sv
// Control bundle between the sequencer, the Fibonacci datapath and the three
// interval timers; master is the sequencer side.
interface fib_seq_ctrl_if;

    logic start_in;
    logic zero_flag_in;
    logic t0_int_in;
    logic t1_int_in;
    logic t2_int_in;
    logic mux_sel_out;
    logic x1_set_out;
    logic x2_set_out;
    logic x3_set_out;
    logic x4_set_out;
    logic t0_start_out;
    logic t1_start_out;
    logic t2_start_out;
    logic led_out;
    logic busy_out;
    logic done_out;

    modport master (
        input  start_in, zero_flag_in, t0_int_in, t1_int_in, t2_int_in,
        output mux_sel_out, x1_set_out, x2_set_out, x3_set_out, x4_set_out,
        output t0_start_out, t1_start_out, t2_start_out,
        output led_out, busy_out, done_out
    );

    modport slave (
        output start_in, zero_flag_in, t0_int_in, t1_int_in, t2_int_in,
        input  mux_sel_out, x1_set_out, x2_set_out, x3_set_out, x4_set_out,
        input  t0_start_out, t1_start_out, t2_start_out,
        input  led_out, busy_out, done_out
    );

endinterface

// File: rtl/fib_seq_ctrl.sv
// Sequencer for the 4-bit Fibonacci datapath: iterates the count held in x4,
// loads the result back into x4, then blinks the LED once per unit of it.
module fib_seq_ctrl
    import fib_pkg::*;
#(
    parameter int REPEAT     = 0,
    parameter int STEP_LIMIT = 255
) (
    input  logic           clock_in,
    input  logic           reset_in,
    fib_seq_ctrl_if.master bus
);

    localparam logic [STEP_CNT_WIDTH-1:0] LIMIT_C  = STEP_CNT_WIDTH'(STEP_LIMIT);
    localparam logic                      REPEAT_C = (REPEAT != 0);

    state_t                    state_r;
    logic [STEP_CNT_WIDTH-1:0] step_cnt_r;
    logic                      led_r;
    logic                      step_exit_s;
    logic                      seq_set_s;
    logic                      x4_set_s;
    logic                      mux_sel_s;
    logic                      t0_start_s;
    logic                      t1_start_s;
    logic                      t2_start_s;
    logic                      busy_s;
    logic                      done_s;

    assign step_exit_s = step_exit(bus.zero_flag_in, step_cnt_r, LIMIT_C);

    // State, step counter and LED register.
    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            state_r    <= ST_IDLE;
            step_cnt_r <= 8'd0;
            led_r      <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (REPEAT_C || bus.start_in) state_r <= ST_STEP;
                end
                ST_STEP: begin
                    if (step_exit_s) state_r    <= ST_LOAD;
                    else             step_cnt_r <= step_cnt_r + 8'd1;
                end
                ST_LOAD: begin
                    step_cnt_r <= 8'd0;
                    state_r    <= ST_CHK;
                end
                ST_CHK: begin
                    if (bus.zero_flag_in) begin
                        state_r <= ST_GAP_WAIT;
                    end else begin
                        led_r   <= 1'b1;
                        state_r <= ST_ON_WAIT;
                    end
                end
                ST_ON_WAIT: begin
                    if (bus.t0_int_in) begin
                        led_r   <= 1'b0;
                        state_r <= ST_OFF_WAIT;
                    end
                end
                ST_OFF_WAIT: begin
                    if (bus.t1_int_in) state_r <= ST_CHK;
                end
                ST_GAP_WAIT: begin
                    if (bus.t2_int_in) state_r <= ST_DONE;
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r    <= ST_IDLE;
                    step_cnt_r <= 8'd0;
                    led_r      <= 1'b0;
                end
            endcase
        end
    end

    // Strobe and timer-start decode; everything idles low unless the state asks.
    always_comb begin
        seq_set_s  = 1'b0;
        x4_set_s   = 1'b0;
        mux_sel_s  = MUX_SEL_ADD;
        t0_start_s = 1'b0;
        t1_start_s = 1'b0;
        t2_start_s = 1'b0;
        busy_s     = (state_r != ST_IDLE);
        done_s     = 1'b0;
        case (state_r)
            ST_STEP: begin
                if (!step_exit_s) begin
                    seq_set_s = 1'b1;
                    x4_set_s  = 1'b1;
                    mux_sel_s = MUX_SEL_DEC;
                end else begin
                    seq_set_s = 1'b0;
                end
            end
            ST_LOAD: begin
                x4_set_s  = 1'b1;
                mux_sel_s = MUX_SEL_ADD;
            end
            ST_CHK: begin
                if (bus.zero_flag_in) t2_start_s = 1'b1;
                else                  t0_start_s = 1'b1;
            end
            ST_ON_WAIT: begin
                if (bus.t0_int_in) begin
                    t1_start_s = 1'b1;
                    x4_set_s   = 1'b1;
                    mux_sel_s  = MUX_SEL_DEC;
                end else begin
                    t1_start_s = 1'b0;
                end
            end
            ST_DONE: begin
                done_s = 1'b1;
            end
            default: begin
                done_s = 1'b0;
            end
        endcase
    end

    assign bus.x1_set_out   = seq_set_s;
    assign bus.x2_set_out   = seq_set_s;
    assign bus.x3_set_out   = seq_set_s;
    assign bus.x4_set_out   = x4_set_s;
    assign bus.mux_sel_out  = mux_sel_s;
    assign bus.t0_start_out = t0_start_s;
    assign bus.t1_start_out = t1_start_s;
    assign bus.t2_start_out = t2_start_s;
    assign bus.led_out      = led_r;
    assign bus.busy_out     = busy_s;
    assign bus.done_out     = done_s;

endmodule

// File: tb/tb_fib_seq_ctrl.sv
// Bench for fib_seq_ctrl: per-run cycle schedules (stimulus plus expected
// outputs) derived from the iterate/load/blink/gap rules, replayed on three configurations.
module tb_fib_seq_ctrl;

    // Expected-output bit positions: {x1,x2,x3,x4,mux,t0s,t1s,t2s,led,busy,done}
    localparam logic [10:0] E_DONE = 11'h001;
    localparam logic [10:0] E_BUSY = 11'h002;
    localparam logic [10:0] E_LED  = 11'h004;
    localparam logic [10:0] E_T2S  = 11'h008;
    localparam logic [10:0] E_T1S  = 11'h010;
    localparam logic [10:0] E_T0S  = 11'h020;
    localparam logic [10:0] E_DEC  = 11'h0C0;
    localparam logic [10:0] E_LOAD = 11'h080;
    localparam logic [10:0] E_STEP = 11'h7C0;

    typedef struct packed {
        logic        rst;
        logic        start;
        logic        zero;
        logic        i0;
        logic        i1;
        logic        i2;
        logic        chk;
        logic [10:0] exp;
    } cyc_t;

    cyc_t sched[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   n_step, n_x4, n_led, n_t0s, n_t2s, n_done, n_busy;

    logic clk = 1'b0;
    logic rst_m = 1'b1;
    logic rst_r = 1'b1;
    logic rst_l = 1'b1;

    always #5 clk = ~clk;

    fib_seq_ctrl_if bus_m ();
    fib_seq_ctrl_if bus_r ();
    fib_seq_ctrl_if bus_l ();

    fib_seq_ctrl #(.REPEAT(0), .STEP_LIMIT(255)) dut_m (.clock_in(clk), .reset_in(rst_m), .bus(bus_m));
    fib_seq_ctrl #(.REPEAT(1), .STEP_LIMIT(255)) dut_r (.clock_in(clk), .reset_in(rst_r), .bus(bus_r));
    fib_seq_ctrl #(.REPEAT(0), .STEP_LIMIT(4))   dut_l (.clock_in(clk), .reset_in(rst_l), .bus(bus_l));

    function automatic bit rb(int pct);
        return $urandom_range(0, 99) < pct;
    endfunction

    function automatic int pick(int fixed);
        return (fixed > 0) ? fixed : int'($urandom_range(1, 4));
    endfunction

    task automatic push(bit rst, bit st, bit z, bit i0, bit i1, bit i2, logic [10:0] e);
        cyc_t c;
        c.rst = rst; c.start = st; c.zero = z; c.i0 = i0; c.i1 = i1; c.i2 = i2;
        c.chk = 1'b1; c.exp = e;
        sched.push_back(c);
    endtask

    task automatic push_reset();
        cyc_t c;
        c = '0;
        c.rst = 1'b1;
        sched.push_back(c);
    endtask

    // One start-to-DONE transaction: n = initial x4, r = loaded result.
    task automatic run(int n, int r, int gap, bit rep, int limit,
                       int don, int doff, int dgap, int rst_blink);
        int x4;
        int k;
        int d;
        x4 = n;
        for (int i = 0; i < gap; i++)
            push(1'b0, !rep && (i == gap - 1), x4 == 0, rb(20), rb(20), rb(20), 11'h000);
        k = (n < limit) ? n : limit;
        for (int j = 0; j < k; j++) begin
            push(1'b0, rb(50), 1'b0, rb(20), rb(20), rb(20), E_STEP | E_BUSY);
            x4--;
        end
        push(1'b0, rb(50), x4 == 0, rb(20), rb(20), rb(20), E_BUSY);
        push(1'b0, rb(50), x4 == 0, rb(20), rb(20), rb(20), E_LOAD | E_BUSY);
        x4 = r;
        for (int b = 0; b < r; b++) begin
            push(1'b0, rb(50), 1'b0, rb(30), rb(20), rb(20), E_T0S | E_BUSY);
            d = (b == rst_blink) ? 4 : pick(don);
            for (int c = 0; c < d; c++) begin
                if (b == rst_blink && c == 1) begin
                    push(1'b1, rb(50), 1'b0, 1'b0, rb(50), rb(50), E_LED | E_BUSY);
                    return;
                end
                push(1'b0, rb(50), 1'b0, c == d - 1, rb(50), rb(50),
                     (c == d - 1) ? (E_LED | E_BUSY | E_T1S | E_DEC) : (E_LED | E_BUSY));
            end
            x4--;
            d = pick(doff);
            for (int c = 0; c < d; c++)
                push(1'b0, rb(50), x4 == 0, rb(30), c == d - 1, rb(30), E_BUSY);
        end
        push(1'b0, rb(50), 1'b1, rb(30), rb(30), rb(30), E_T2S | E_BUSY);
        d = pick(dgap);
        for (int c = 0; c < d; c++)
            push(1'b0, rb(50), 1'b1, rb(30), rb(30), c == d - 1, E_BUSY);
        push(1'b0, rb(50), 1'b1, rb(30), rb(30), rb(30), E_DONE | E_BUSY);
    endtask

    task automatic drive(int d, cyc_t c);
        case (d)
            0: begin
                rst_m = c.rst; bus_m.start_in = c.start; bus_m.zero_flag_in = c.zero;
                bus_m.t0_int_in = c.i0; bus_m.t1_int_in = c.i1; bus_m.t2_int_in = c.i2;
            end
            1: begin
                rst_r = c.rst; bus_r.start_in = c.start; bus_r.zero_flag_in = c.zero;
                bus_r.t0_int_in = c.i0; bus_r.t1_int_in = c.i1; bus_r.t2_int_in = c.i2;
            end
            default: begin
                rst_l = c.rst; bus_l.start_in = c.start; bus_l.zero_flag_in = c.zero;
                bus_l.t0_int_in = c.i0; bus_l.t1_int_in = c.i1; bus_l.t2_int_in = c.i2;
            end
        endcase
    endtask

    function automatic logic [10:0] sample(int d);
        case (d)
            0: return {bus_m.x1_set_out, bus_m.x2_set_out, bus_m.x3_set_out, bus_m.x4_set_out,
                       bus_m.mux_sel_out, bus_m.t0_start_out, bus_m.t1_start_out,
                       bus_m.t2_start_out, bus_m.led_out, bus_m.busy_out, bus_m.done_out};
            1: return {bus_r.x1_set_out, bus_r.x2_set_out, bus_r.x3_set_out, bus_r.x4_set_out,
                       bus_r.mux_sel_out, bus_r.t0_start_out, bus_r.t1_start_out,
                       bus_r.t2_start_out, bus_r.led_out, bus_r.busy_out, bus_r.done_out};
            default: return {bus_l.x1_set_out, bus_l.x2_set_out, bus_l.x3_set_out, bus_l.x4_set_out,
                       bus_l.mux_sel_out, bus_l.t0_start_out, bus_l.t1_start_out,
                       bus_l.t2_start_out, bus_l.led_out, bus_l.busy_out, bus_l.done_out};
        endcase
    endfunction

    task automatic clr();
        n_step = 0; n_x4 = 0; n_led = 0; n_t0s = 0; n_t2s = 0; n_done = 0; n_busy = 0;
    endtask

    task automatic lit(string nm, int act, int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s act=%0d exp=%0d", nm, act, exp);
        end
    endtask

    // Replays the queued schedule on DUT d: drive at negedge, compare 1 ns later.
    task automatic exec(int d);
        cyc_t        c;
        logic [10:0] act;
        int          idx;
        idx = 0;
        while (sched.size() > 0) begin
            c = sched.pop_front();
            @(negedge clk);
            drive(d, c);
            #1;
            act = sample(d);
            if (c.chk) begin
                vectors++;
                if (act !== c.exp) begin
                    miscompares++;
                    $display("FAIL dut%0d cyc%0d outputs act=%b exp=%b", d, idx, act, c.exp);
                end
            end
            n_step += int'(act[10]); n_x4 += int'(act[7]); n_t0s += int'(act[5]);
            n_t2s  += int'(act[3]);  n_led += int'(act[2]); n_busy += int'(act[1]);
            n_done += int'(act[0]);
            idx++;
        end
    endtask

    initial begin
        int n;
        int r;
        drive(0, cyc_t'(0)); drive(1, cyc_t'(0)); drive(2, cyc_t'(0));
        rst_m = 1'b1; rst_r = 1'b1; rst_l = 1'b1;

        // Main configuration: count 3, result 2, fixed timer periods.
        push_reset();
        run(3, 2, 2, 1'b0, 255, 2, 3, 2, -1);
        clr();
        exec(0);
        lit("seq_strobes", n_step, 3);
        lit("x4_strobes", n_x4, 6);
        lit("led_cycles", n_led, 4);
        lit("t0_starts", n_t0s, 2);
        lit("done_pulses", n_done, 1);
        lit("busy_cycles", n_busy, 21);

        // Result 0: no blink, gap straight after CHK.
        run(0, 0, 1, 1'b0, 255, 1, 1, 2, -1);
        clr();
        exec(0);
        lit("zero_busy", n_busy, 6);
        lit("zero_t0s", n_t0s, 0);
        lit("zero_led", n_led, 0);
        lit("zero_t2s", n_t2s, 1);

        // Reset in the middle of the second blink, then random traffic.
        run(4, 3, 3, 1'b0, 255, 0, 0, 0, 1);
        for (int i = 0; i < 25; i++) begin
            r = int'($urandom_range(0, 4));
            run(int'($urandom_range(0, 8)), r, int'($urandom_range(1, 3)), 1'b0, 255, 0, 0, 0,
                (r > 0 && rb(15)) ? int'($urandom_range(0, r - 1)) : -1);
        end
        exec(0);
        rst_m = 1'b1;

        // Hang guard: count never reaches zero, limit 4.
        push_reset();
        run(9, 1, 2, 1'b0, 4, 1, 1, 1, -1);
        clr();
        exec(2);
        lit("limit_steps", n_step, 4);
        for (int i = 0; i < 10; i++)
            run(int'($urandom_range(0, 12)), int'($urandom_range(0, 3)),
                int'($urandom_range(1, 3)), 1'b0, 4, 0, 0, 0, -1);
        exec(2);
        rst_l = 1'b1;

        // Auto-repeat: STEP one cycle after reset release and after each DONE.
        push_reset();
        for (int i = 0; i < 8; i++) begin
            n = int'($urandom_range(0, 6));
            run(n, int'($urandom_range(0, 3)), 1, 1'b1, 255, 0, 0, 0, -1);
        end
        clr();
        exec(1);
        lit("repeat_dones", n_done, 8);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fib_seq_ctrl.md
# fib_seq_ctrl

Sequencing controller for the 4-bit Fibonacci datapath (x1–x4 registers, adder, decrementer, mux, zero detector) and its three interval timers. It runs the Fibonacci iteration loop for the count preloaded in x4, then loads the result into x4. It then blinks `led_out` once per unit of that result, using the on, off and gap timers. The block sits between the top level and the datapath and is its only source of register-set strobes and timer starts.

## Interface
Parameters:
- `REPEAT`, 0: 1 = after DONE, restart the iteration phase automatically without `start_in`.
- `STEP_LIMIT`, 255: maximum STEP cycles before forced exit to LOAD (hang guard); 8-bit counter.

Ports:
- `clock_in`  in  1  single system clock.
- `reset_in`  in  1  synchronous, active-high reset.
- `start_in`  in  1  level; sampled only in IDLE.
- `zero_flag_in`  in  1  x4 == 0, from zero detector.
- `t0_int_in` / `t1_int_in` / `t2_int_in`  in  1  one-cycle pulses: on-time, off-time, gap-time elapsed.
- `mux_sel_out`  out  1  0 = adder result, 1 = decremented x4.
- `x1_set_out` / `x2_set_out` / `x3_set_out` / `x4_set_out`  out  1  datapath register load strobes.
- `t0_start_out` / `t1_start_out` / `t2_start_out`  out  1  one-cycle timer start pulses.
- `led_out`  out  1  registered LED drive.
- `busy_out`  out  1  high in every state except IDLE.
- `done_out`  out  1  one-cycle pulse in DONE.

## Operation
States: IDLE, STEP, LOAD, CHK, ON_WAIT, OFF_WAIT, GAP_WAIT, DONE.
- Strobes, starts and `mux_sel_out` are decoded combinationally from state and inputs. `led_out` is registered. All outputs default to 0.
- IDLE: if `start_in` = 1, go to STEP. If `REPEAT` = 1, go to STEP unconditionally, including the first cycle after reset.
- STEP:
  - If `zero_flag_in` = 1, or the step counter equals `STEP_LIMIT`, go to LOAD.
  - Otherwise assert x1/x2/x3_set, x4_set and mux_sel = 1 for one cycle (advance sequence, decrement count), and increment the step counter.
- LOAD: assert x4_set with mux_sel = 0 for one cycle (x4 ← adder result). Clear the step counter. Go to CHK.
- CHK:
  - If `zero_flag_in` = 1: pulse t2_start and go to GAP_WAIT.
  - Otherwise: pulse t0_start, set `led_out` to 1, and go to ON_WAIT.
- ON_WAIT: on `t0_int_in`, clear `led_out`, pulse t1_start, assert x4_set with mux_sel = 1, and go to OFF_WAIT.
- OFF_WAIT: on `t1_int_in`, go to CHK.
- GAP_WAIT: on `t2_int_in`, go to DONE.
- DONE: assert `done_out` and go to IDLE.
- Timer interrupts are honoured only in their own wait state. All other interrupts are ignored and never queued.
- `start_in` is ignored while busy.
- The controller never clears x1–x3. Re-seeding the sequence is done only by `reset_in`.

## Timing
- Reset, synchronous and active-high: the next state is IDLE, `led_out` = 0, and the step counter = 0. `reset_in` overrides every state, including mid-blink, and drops `led_out` on the following edge.
- Latencies:
  - `start_in` to the first STEP strobe: 1 cycle.
  - Each iteration: 1 cycle.
  - LOAD: exactly 1 cycle.
  - `t0_int_in` to `led_out` falling: 1 cycle.
  - CHK to `led_out` rising: 1 cycle.
- Each blink costs on + off timer periods plus 1 cycle for CHK.
- Result 0 gives no blink: the gap follows immediately.
- An interrupt arriving in the same cycle as its start pulse is not in the wait state yet, so it is ignored.
- The step-counter guard caps STEP residency at `STEP_LIMIT` + 1 cycles.

## Structure
- Shared package `fib_pkg`: state encoding localparams (3 bits), `MUX_SEL_ADD` = 0, `MUX_SEL_DEC` = 1, and `DATA_WIDTH` = 4.
- Single FSM module; no sub-module is warranted.
- Timers remain external instances wired at top level.

## Test plan
- Reset, then `start_in` pulse with x4 reset value 3 → three consecutive STEP cycles with all four set strobes and mux_sel = 1, then one LOAD cycle with only x4_set and mux_sel = 0.
- Bench datapath model loads result 2 into x4 → exactly two LED pulses, each high from CHK+1 until `t0_int_in`+1, with x4_set/mux_sel = 1 at each `t0_int_in`; then t2_start, and `done_out` one cycle after `t2_int_in`.
- Result 0 → no t0_start and `led_out` stays 0; t2_start fires 1 cycle after LOAD.
- Stray `t1_int_in` and `t2_int_in` during ON_WAIT, plus `start_in` held high while busy → no state change and no extra strobes.
- `reset_in` asserted during ON_WAIT → `led_out` = 0 and `busy_out` = 0 on the next edge, and all strobes are 0.
- `REPEAT` = 1 with `start_in` tied 0 → STEP entered one cycle after reset release, and again one cycle after each `done_out`.
- `zero_flag_in` forced 0 with `STEP_LIMIT` = 4 → exactly 4 STEP strobe cycles, then LOAD.
